// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Radix-2 shift-add multiply and restoring divide over XLEN cycles on unsigned
// magnitudes, with sign fix-up in a final cycle and a fast path for the
// divide-by-zero and signed-overflow cases.
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_next;
  logic [2:0]          op;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     opb;
  logic [2*XLEN-1:0]   acc;
  logic [CNT_W-1:0]    counter;
  logic [XLEN-1:0]     result_q;

  logic                accept;
  logic                signed_a_in, signed_b_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_zero, div_ovf, fast;
  logic [XLEN-1:0]     fast_val;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step;
  logic [XLEN:0]       div_shift;
  logic [XLEN+1:0]     div_diff;
  logic                no_borrow;
  logic [XLEN-1:0]     new_rem;
  logic [2*XLEN-1:0]   div_step;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

  assign result = result_q;
  assign accept = start && !flush && (state == IDLE);

  // Decode the raw request: operand signedness, magnitudes and fast-path result.
  always_comb begin
    signed_a_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in    = signed_a_in && rs1[XLEN-1];
    b_neg_in    = signed_b_in && rs2[XLEN-1];
    abs_a       = a_neg_in ? (~rs1 + 1'b1) : rs1;
    abs_b       = b_neg_in ? (~rs2 + 1'b1) : rs2;
    div_zero    = funct3[2] && (rs2 == '0);
    div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                  (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    fast        = div_zero || div_ovf;
    fast_val    = '0;
    if (div_zero)
      fast_val = funct3[1] ? rs1 : '1;
    else if (div_ovf)
      fast_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of each algorithm plus the sign fix-up and output select.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    mul_step  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    no_borrow = !div_diff[XLEN+1];
    new_rem   = no_borrow ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_step  = {new_rem, acc[XLEN-2:0], no_borrow};
    prod_fix  = (a_neg ^ b_neg) ? (~acc + 1'b1) : acc;
    quo_fix   = (a_neg ^ b_neg) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix   = a_neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:         fix_val = prod_fix[XLEN-1:0];
      3'b100, 3'b101: fix_val = quo_fix;
      3'b110, 3'b111: fix_val = rem_fix;
      default:        fix_val = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs; flush always returns to IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = fast ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (counter == CNT_W'(XLEN-1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: latch operands, iterate, and commit the result when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      counter  <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op      <= funct3;
          a_neg   <= a_neg_in;
          b_neg   <= b_neg_in;
          counter <= '0;
          if (fast) begin
            result_q <= fast_val;
          end else if (funct3[2]) begin
            acc <= {{XLEN{1'b0}}, abs_a};
            opb <= abs_b;
          end else begin
            acc <= {{XLEN{1'b0}}, abs_b};
            opb <= abs_a;
          end
        end
        CALC: begin
          acc     <= op[2] ? div_step : mul_step;
          counter <= counter + 1'b1;
        end
        FIX: if (!flush) result_q <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops against an
// arithmetic reference model, and hand-written flush/reset/start-hold sequences.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of an RV32M op computed with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present one request in the current cycle (cycle 0) and follow it until done.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input bit hold_start, output logic [31:0] res,
                               output int done_cyc, output int busy_cnt, output int last_busy);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    done_cyc = -1; busy_cnt = 0; last_busy = 0; res = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold_start) start = 1'b0;
        rs1 = $urandom; rs2 = $urandom;
      end
      if (busy) begin busy_cnt++; last_busy = c; end
      if (done) begin
        done_cyc = c; res = result; start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, last_exp, a, b, exp;
    logic [2:0]  f;
    int          dcyc, bcnt, lbusy, dcount, lat;
    string       tag;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,       34};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,        34};
    vecs[8]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[13] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);

    $display("[TB] directed table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, res, dcyc, bcnt, lbusy);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, "_result"}, res, vecs[i].exp);
      checkOutput({tag, "_done_cycle"}, 32'(dcyc), 32'(vecs[i].lat));
      checkOutput({tag, "_busy_cycles"}, 32'(bcnt), 32'(vecs[i].lat - 1));
      checkOutput({tag, "_last_busy"}, 32'(lbusy), 32'((vecs[i].lat > 1) ? 33 : 0));
      @(negedge clk);
      checkOutput({tag, "_after_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_after_done"}, 32'(done), 32'd0);
      last_exp = vecs[i].exp;
    end

    $display("[TB] random ops");
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(f, a, b);
      lat = ref_latency(f, a, b);
      applyStimulus(f, a, b, 1'b0, res, dcyc, bcnt, lbusy);
      tag = $sformatf("rand%0d_f%0d_%h_%h", i, f, a, b);
      checkOutput({tag, "_result"}, res, exp);
      checkOutput({tag, "_done_cycle"}, 32'(dcyc), 32'(lat));
      checkOutput({tag, "_busy_cycles"}, 32'(bcnt), 32'(lat - 1));
      @(negedge clk);
      last_exp = exp;
    end

    $display("[TB] flush together with start in IDLE");
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1 = 32'h1234; rs2 = 32'h0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_start_done", 32'(done), 32'd0);
    checkOutput("flush_start_busy", 32'(busy), 32'd0);
    dcount = 0;
    repeat (4) begin @(negedge clk); if (done || busy) dcount++; end
    checkOutput("flush_start_idle", 32'(dcount), 32'd0);
    checkOutput("flush_start_result", result, last_exp);

    $display("[TB] flush mid-divide");
    start = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
    dcount = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) dcount++;
      if (c == 10) begin
        checkOutput("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
      end
    end
    flush = 1'b0;
    checkOutput("flush_busy_after", 32'(busy), 32'd0);
    checkOutput("flush_no_done", 32'(dcount + int'(done)), 32'd0);
    checkOutput("flush_result_kept", result, last_exp);
    applyStimulus(3'd5, 32'd100, 32'd7, 1'b0, res, dcyc, bcnt, lbusy);
    checkOutput("post_flush_done_cycle", 32'(dcyc + 11), 32'd45);
    checkOutput("post_flush_result", res, 32'd14);
    @(negedge clk);

    $display("[TB] start held while busy");
    applyStimulus(3'd0, 32'd12345, 32'd678, 1'b1, res, dcyc, bcnt, lbusy);
    checkOutput("hold_result", res, 32'd8369910);
    checkOutput("hold_done_cycle", 32'(dcyc), 32'd34);
    dcount = 0;
    repeat (40) begin @(negedge clk); if (done || busy) dcount++; end
    checkOutput("hold_no_second", 32'(dcount), 32'd0);

    $display("[TB] reset mid-multiply");
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd99; rs2 = 32'd77;
    dcount = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) dcount++;
      if (c == 20) rst = 1'b1;
    end
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    repeat (40) begin @(negedge clk); if (done || busy) dcount++; end
    checkOutput("midrst_no_done", 32'(dcount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
